mem_burst_reader: RTL

Read-side engine for the team's 256x8 register-array memories. Accepts a burst read request (start address, length) and drives the array's combinational read port. Returns each byte, tagged with its address and a last flag, on a valid/ready output stream. It is the read counterpart to the existing write-side memory logic, and sits between the memory array and any consumer that needs sequential dumps.

---
 rtl/mem_rd_pkg.sv | 33 +++
 rtl/mem_rd_skid.sv | 80 ++++++++
 rtl/mem_burst_reader.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_rd_pkg.sv
// Shared types and defaults for the memory burst read engine.
package mem_rd_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One output beat at the default geometry: byte, its source address, end-of-burst flag.
  typedef struct packed {
    logic [DW_DEF-1:0] data;
    logic [AW_DEF-1:0] addr;
    logic              last;
  } beat_t;

  localparam int unsigned BEAT_W = $bits(beat_t);

  // Assemble a default-geometry beat from its fields.
  function automatic beat_t make_beat(input logic [DW_DEF-1:0] data,
                                      input logic [AW_DEF-1:0] addr,
                                      input logic              last);
    beat_t b;
    b.data = data;
    b.addr = addr;
    b.last = last;
    return b;
  endfunction

endpackage

// File: rtl/mem_rd_skid.sv
// Two-entry valid/ready buffer; the head entry drives the registered output.
module mem_rd_skid
  import mem_rd_pkg::*;
#(
  parameter int unsigned PW = BEAT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [PW-1:0] i_push_data,
  output logic          o_space_c,
  input  logic          i_pop_ready,
  output logic          o_valid,
  output logic [PW-1:0] o_data,
  output logic [1:0]    o_count
);

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [1:0]    r_count;
  logic          r_valid;

  logic [PW-1:0] w_head_nxt;
  logic [PW-1:0] w_tail_nxt;
  logic [1:0]    w_count_nxt;
  logic          w_pop;
  logic          w_push_ok;

  assign w_pop     = r_valid && i_pop_ready;
  // A pop on a full buffer frees a slot for a same-cycle push.
  assign o_space_c = (r_count < 2'd2) || w_pop;
  assign w_push_ok = i_push && o_space_c;

  assign o_valid = r_valid;
  assign o_data  = r_head;
  assign o_count = r_count;

  // Next entry contents and occupancy for every push/pop combination.
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop})
      2'b10: begin
        if (r_count == 2'd0) w_head_nxt = i_push_data;
        else                 w_tail_nxt = i_push_data;
        w_count_nxt = r_count + 2'd1;
      end
      2'b01: begin
        w_head_nxt  = r_tail;
        w_count_nxt = r_count - 2'd1;
      end
      2'b11: begin
        if (r_count == 2'd1) begin
          w_head_nxt = i_push_data;
        end else begin
          w_head_nxt = r_tail;
          w_tail_nxt = i_push_data;
        end
      end
      default: ;
    endcase
  end

  // Buffer storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != 2'd0);
    end
  end

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read engine: walks a combinational array read port and streams tagged bytes.
module mem_burst_reader
  import mem_rd_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_len,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          busy
);

  localparam int unsigned PW = DW + AW + 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cur_addr;
  logic [AW-1:0] w_cur_addr_nxt;
  logic [AW-1:0] r_remaining;
  logic [AW-1:0] w_remaining_nxt;

  logic          w_push;
  logic          w_space;
  logic          w_pop;
  logic [1:0]    w_count;
  logic [PW-1:0] w_push_data;
  logic [PW-1:0] w_head;

  assign w_pop       = out_valid && out_ready;
  assign w_push_data = {mem_rdata, r_cur_addr, (r_remaining == '0)};

  mem_rd_skid #(
    .PW (PW)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .o_space_c   (w_space),
    .i_pop_ready (out_ready),
    .o_valid     (out_valid),
    .o_data      (w_head),
    .o_count     (w_count)
  );

  assign {out_data, out_addr, out_last} = w_head;

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign mem_addr  = r_cur_addr;
  assign mem_re    = w_push;

  // FSM state, address counter and beats-remaining counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_addr  <= w_cur_addr_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  // Next-state, counter updates and read strobe.
  always_comb begin
    w_state_nxt     = r_state;
    w_cur_addr_nxt  = r_cur_addr;
    w_remaining_nxt = r_remaining;
    w_push          = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_cur_addr_nxt  = req_addr;
          w_remaining_nxt = req_len;
          w_state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        if (w_space) begin
          w_push          = 1'b1;
          w_cur_addr_nxt  = r_cur_addr + AW'(1);
          w_remaining_nxt = r_remaining - AW'(1);
          if (r_remaining == '0) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // No pushes here, so popping the only entry empties the buffer.
        if (w_pop && (w_count == 2'd1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
